// File: rtl/track_if.sv
// Front-panel / note-memory bundle for the record/playback sequencer.
interface track_if;
  logic        tick;
  logic [4:0]  btn;
  logic        sw1;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [1:0]  state;
  logic [2:0]  slot;
  logic        note_valid;

  modport master (output tick, btn, sw1,
                  input  mem_addr, mem_we, state, slot, note_valid);
  modport slave  (input  tick, btn, sw1,
                  output mem_addr, mem_we, state, slot, note_valid);
endinterface

// File: rtl/track_controller.sv
// Record/playback sequencer: five fixed slots in the 16K note store,
// addresses and write strobes driven from the note-rate tick.
module track_controller #(
  parameter int SLOT_DEPTH = 3264,
  parameter bit LOOP       = 1'b0
) (
  input  logic    clk,
  input  logic    reset,
  track_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, REC = 2'd2} state_t;

  // Slot bases are elaboration-time constants, so the mux below needs no multiplier.
  localparam logic [13:0] BASE1   = 14'(SLOT_DEPTH);
  localparam logic [13:0] BASE2   = 14'(2 * SLOT_DEPTH);
  localparam logic [13:0] BASE3   = 14'(3 * SLOT_DEPTH);
  localparam logic [13:0] BASE4   = 14'(4 * SLOT_DEPTH);
  localparam logic [12:0] DEPTH13 = 13'(SLOT_DEPTH);
  localparam logic [11:0] DEPTH12 = 12'(SLOT_DEPTH);

  function automatic logic [13:0] base_of(input logic [2:0] k);
    case (k)
      3'd1:    base_of = BASE1;
      3'd2:    base_of = BASE2;
      3'd3:    base_of = BASE3;
      3'd4:    base_of = BASE4;
      default: base_of = 14'd0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  slot_q, slot_d;
  logic [11:0] pos_q, pos_d;
  logic [13:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [4:0]  btn_q;
  logic [11:0] len [5];

  logic        len_we;
  logic [2:0]  len_idx;
  logic [11:0] len_val;

  logic [4:0]  press;
  logic        has_press;
  logic [2:0]  press_idx;
  logic [12:0] pos_inc;
  logic [11:0] len_cur;

  assign press     = bus.btn & ~btn_q;
  assign has_press = |press;
  assign pos_inc   = {1'b0, pos_q} + 13'd1;
  assign len_cur   = len[slot_q];

  // Lowest-index button wins when several rise together.
  always_comb begin
    press_idx = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (press[i]) press_idx = 3'(i);
  end

  // Next-state, next-address and slot-length update.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    pos_d   = pos_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    len_we  = 1'b0;
    len_idx = slot_q;
    len_val = pos_q;
    if (state_q != REC && has_press) begin
      // IDLE and PLAY treat a press identically.
      if (bus.sw1) begin
        state_d = REC;
        slot_d  = press_idx;
        pos_d   = 12'd0;
        len_we  = 1'b1;
        len_idx = press_idx;
        len_val = 12'd0;
      end else if (len[press_idx] != 12'd0) begin
        state_d = PLAY;
        slot_d  = press_idx;
        pos_d   = 12'd0;
        addr_d  = base_of(press_idx);
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        REC: begin
          // An exit in the same cycle as a tick drops the tick.
          if (has_press || !bus.sw1) begin
            len_we  = 1'b1;
            len_val = pos_q;
            state_d = IDLE;
          end else if (bus.tick) begin
            addr_d = base_of(slot_q) + 14'(pos_q);
            we_d   = 1'b1;
            pos_d  = pos_inc[11:0];
            if (pos_inc == DEPTH13) begin
              len_we  = 1'b1;
              len_val = DEPTH12;
              state_d = IDLE;
            end
          end
        end
        PLAY: begin
          if (bus.tick) begin
            if (pos_inc < {1'b0, len_cur}) begin
              pos_d  = pos_inc[11:0];
              addr_d = base_of(slot_q) + 14'(pos_inc);
            end else if (LOOP) begin
              pos_d  = 12'd0;
              addr_d = base_of(slot_q);
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, address and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= 3'd0;
      pos_q   <= 12'd0;
      addr_q  <= 14'd0;
      we_q    <= 1'b0;
      btn_q   <= 5'b11111;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      pos_q   <= pos_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      btn_q   <= bus.btn;
    end
  end

  // Per-slot track lengths; reset also discards a track being recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) len[i] <= 12'd0;
    end else if (len_we) begin
      len[len_idx] <= len_val;
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_we     = we_q;
  assign bus.state      = state_q;
  assign bus.slot       = slot_q;
  assign bus.note_valid = (state_q == PLAY);

endmodule

// File: tb/tb_track_controller.sv
// Directed bench: dut_a full-size slots without loop, dut_b 4-entry slots with loop.
module tb_track_controller;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  track_if ifa();
  track_if ifb();

  track_controller #(.SLOT_DEPTH(3264), .LOOP(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  track_controller #(.SLOT_DEPTH(4),    .LOOP(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] st_of(input int d);
    return (d == 0) ? 32'(ifa.state) : 32'(ifb.state);
  endfunction
  function automatic logic [31:0] addr_of(input int d);
    return (d == 0) ? 32'(ifa.mem_addr) : 32'(ifb.mem_addr);
  endfunction
  function automatic logic [31:0] we_of(input int d);
    return (d == 0) ? 32'(ifa.mem_we) : 32'(ifb.mem_we);
  endfunction
  function automatic logic [31:0] slot_of(input int d);
    return (d == 0) ? 32'(ifa.slot) : 32'(ifb.slot);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int d, input logic t, input logic [4:0] b, input logic s);
    if (d == 0) begin ifa.tick = t; ifa.btn = b; ifa.sw1 = s; end
    else        begin ifb.tick = t; ifb.btn = b; ifb.sw1 = s; end
  endtask

  // One clock; any write strobe is matched against the scoreboard.
  task automatic cycle(input int d);
    logic [31:0] e;
    int n;
    @(posedge clk);
    @(negedge clk);
    if (we_of(d) == 32'd1) begin
      n = (d == 0) ? qa.size() : qb.size();
      if (n == 0) chk("spurious_we", 32'd1, 32'd0);
      else begin
        e = (d == 0) ? qa.pop_front() : qb.pop_front();
        chk("wr_addr", addr_of(d), e);
      end
    end
  endtask

  task automatic press(input int d, input logic [4:0] mask, input logic s);
    set_in(d, 1'b0, mask, s);
    cycle(d);
    set_in(d, 1'b0, 5'd0, s);
  endtask

  task automatic tk(input int d, input logic s);
    set_in(d, 1'b1, 5'd0, s);
    cycle(d);
    set_in(d, 1'b0, 5'd0, s);
    cycle(d);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    set_in(0, 1'b0, 5'b00100, 1'b0);
    set_in(1, 1'b0, 5'b00000, 1'b0);

    // Reset with btn[2] held: no press afterwards.
    for (int i = 0; i < 3; i++) begin
      cycle(0);
      chk("rst_state", st_of(0), 0);
      chk("rst_addr", addr_of(0), 0);
    end
    chk("rst_we", we_of(0), 0);
    chk("rst_nv", 32'(ifa.note_valid), 0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(0);
      chk("held_btn_state", st_of(0), 0);
      chk("held_btn_we", we_of(0), 0);
    end
    set_in(0, 1'b0, 5'd0, 1'b0);
    cycle(0);

    // Record three notes into slot 2.
    press(0, 5'b00100, 1'b1);
    chk("rec_state", st_of(0), 2);
    chk("rec_slot", slot_of(0), 2);
    qa.push_back(6528); tk(0, 1'b1);
    qa.push_back(6529); tk(0, 1'b1);
    qa.push_back(6530); tk(0, 1'b1);
    press(0, 5'b00100, 1'b1);
    chk("rec_end_state", st_of(0), 0);
    cycle(0);

    // Play slot 2 back without looping.
    press(0, 5'b00100, 1'b0);
    chk("play_state", st_of(0), 1);
    chk("play_addr0", addr_of(0), 6528);
    chk("play_nv", 32'(ifa.note_valid), 1);
    tk(0, 1'b0);
    chk("play_addr1", addr_of(0), 6529);
    tk(0, 1'b0);
    chk("play_addr2", addr_of(0), 6530);
    chk("play_mid_state", st_of(0), 1);
    tk(0, 1'b0);
    chk("play_end_state", st_of(0), 0);
    chk("play_end_nv", 32'(ifa.note_valid), 0);

    // Empty slot 4: stays idle, slot untouched.
    press(0, 5'b10000, 1'b0);
    chk("empty_state", st_of(0), 0);
    chk("empty_slot", slot_of(0), 2);
    cycle(0);

    // btn[1] and btn[3] together: slot 1 wins.
    press(0, 5'b01010, 1'b1);
    chk("multi_state", st_of(0), 2);
    chk("multi_slot", slot_of(0), 1);
    cycle(0);
    // Tick and press in the same REC cycle: no write, back to IDLE.
    set_in(0, 1'b1, 5'b00001, 1'b1);
    cycle(0);
    set_in(0, 1'b0, 5'd0, 1'b1);
    chk("tickpress_state", st_of(0), 0);
    chk("tickpress_we", we_of(0), 0);
    cycle(0);
    chk("tickpress_we2", we_of(0), 0);
    chk("sb_a_empty", 32'(qa.size()), 0);

    // Full 4-entry slot 1 on dut_b, auto-stop, then looping playback.
    press(1, 5'b00010, 1'b1);
    chk("b_rec_state", st_of(1), 2);
    for (int i = 0; i < 4; i++) begin
      qb.push_back(32'(4 + i));
      tk(1, 1'b1);
    end
    chk("b_full_state", st_of(1), 0);
    press(1, 5'b00010, 1'b0);
    chk("b_play_state", st_of(1), 1);
    chk("b_play_addr0", addr_of(1), 4);
    for (int i = 1; i < 4; i++) begin
      tk(1, 1'b0);
      chk("b_play_addr", addr_of(1), 32'(4 + i));
    end
    tk(1, 1'b0);
    chk("b_wrap_addr", addr_of(1), 4);
    chk("b_wrap_state", st_of(1), 1);
    chk("sb_b_empty", 32'(qb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/track_controller.md
# track_controller

Record/playback sequencer for the note memory. Partitions the 16384-entry note store into five fixed slots, one per front-panel button, and drives the memory address and write enable from the note-rate tick. It records key data into a slot or plays a slot back, replacing the free-running PC/address-mux path. Key data goes straight to memory; this block only sequences addresses and writes.

## Interface

- SLOT_DEPTH, 3264, entries per slot; 5*SLOT_DEPTH ≤ 16384, SLOT_DEPTH ≤ 4095
- LOOP, 0, 1 = playback wraps to slot start; 0 = playback stops at track end
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; sampled on posedge clk
- tick  in  1  one-cycle note-rate strobe from the clock divider
- btn  in  5  slot buttons, btn[0]..btn[4] = slot 0..4, level, already synchronised
- sw1  in  1  1 = record mode, 0 = play mode
- mem_addr  out  14  registered note-memory address
- mem_we  out  1  registered write strobe, one cycle per recorded note
- state  out  2  0 IDLE, 1 PLAY, 2 REC
- slot  out  3  active slot, 0..4
- note_valid  out  1  high while state == PLAY

## Operation

- Slot base address is base(k) = k*SLOT_DEPTH, from constants with no multiplier. The current position is pos, 12 bits. Each slot has a length register len[k], 12 bits, 0 = empty.
- Press detection:
  - press = btn & ~btn_q, where btn_q is btn registered.
  - btn_q resets to 5'b11111, so a button held through reset gives no press.
  - If several buttons rise together, the lowest index wins.
- IDLE:
  - Press k with sw1=1: go to REC, slot=k, pos=0, len[k]=0.
  - Press k with sw1=0 and len[k]≠0: go to PLAY, slot=k, pos=0, mem_addr=base(k).
  - Press k with sw1=0 and len[k]=0: stay in IDLE; slot is unchanged.
- REC:
  - On tick: mem_addr←base(slot)+pos, mem_we←1, pos←pos+1.
  - If pos+1 == SLOT_DEPTH on that tick: len[slot]←SLOT_DEPTH and go to IDLE. The final write still issues.
  - Any press, or sw1=0: len[slot]←pos and go to IDLE. This ends recording.
  - Exit priority is reset > press/sw1 drop > tick. A tick in the same cycle as an exit is discarded and no write occurs.
- PLAY:
  - mem_addr tracks base(slot)+pos.
  - On tick, if pos+1 < len[slot]: pos←pos+1 and mem_addr←base(slot)+pos+1.
  - On tick, if pos+1 == len[slot]: with LOOP=1, pos←0 and mem_addr←base(slot). With LOOP=0, go to IDLE.
  - A press is handled exactly as in IDLE: restart on the new slot, enter REC, or fall to IDLE if the slot is empty. The same button re-pressed restarts its slot at pos 0.
  - sw1 changing alone has no effect in PLAY.
- mem_we is high only in the cycle after a REC tick. It is never high in IDLE or PLAY.
- len registers hold their value across PLAY and IDLE and are cleared only by reset or by entering REC on that slot.

## Timing

- Reset values: state=IDLE, slot=0, pos=0, all len=0, mem_addr=0, mem_we=0, note_valid=0.
- A press registers one cycle after the btn rise. state, slot and mem_addr update on that same edge.
- Tick to mem_we/mem_addr latency is one cycle. The memory sees the address and write enable together, with key data valid that cycle.
- Playback address advances one cycle after tick. Read data latency belongs to the memory.
- Reset mid-REC discards the track: len is cleared and no partial length is kept.
- Ticks closer than one cycle apart are not supported; tick is guaranteed to be at most 1-in-2 cycles.

## Test plan

- Reset with btn=5'b00100 held: no press is detected. state=0, mem_we=0, mem_addr=0 throughout.
- Record slot 2:
  - sw1=1, press btn[2], 3 ticks, then press btn[2]: three mem_we pulses at addresses 6528, 6529, 6530.
  - len[2]=3 and state returns to 0.
- Play slot 2:
  - sw1=0, LOOP=0, press btn[2]: mem_addr=6528.
  - Ticks step it to 6529 and 6530, then state→0 on the 3rd tick. mem_we stays 0.
- Play an empty slot: press btn[4] with len[4]=0: state stays 0 and slot is unchanged.
- Full slot, SLOT_DEPTH=4:
  - Record 4 ticks into slot 1: writes at 4, 5, 6, 7, then automatic IDLE with len[1]=4.
  - LOOP=1 playback wraps 7→4.
- Simultaneous events:
  - In REC, tick and a press in the same cycle: no write, exit to IDLE.
  - btn[1] and btn[3] rising together in IDLE: slot=1.
